rvfi_reg_gen: RTL and testbench
===============================

Name: rvfi_reg_gen

Overview:
- Synthetic RVFI retirement-record source for the formal and simulation benches of the register-consistency checkers.
- Emits a single-channel stream of ADD instructions with pseudo-random rs1, rs2 and rd addresses.
- Keeps a shadow register file so every emitted rs1_rdata, rs2_rdata and post_rd is architecturally consistent.
- Optional fault injection corrupts one read value, so a downstream checker can be shown to fire.

Parameters:
- XLEN, 32: data/PC width.
- NUM_RECORDS, 64: number of records emitted per run; must be ≥1.
- SEED, 32'h00000001: LFSR reset value; a value of 0 is replaced by 1.
- TAPS, 32'h80200003: Galois LFSR feedback mask.
- RESET_PC, 32'h00000000: pre_pc of the first record of each run.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  pulse; starts a run from IDLE or DONE.
- stall  in  1  when high, no record is emitted this cycle.
- seed_load  in  1  loads seed_value into the LFSR.
- seed_value  in  32  new LFSR value; 0 is treated as 1.
- fault_req  in  1  corrupts the next emitted record.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- rvfi_valid  out  1  record strobe.
- rvfi_order  out  8  record index within the run.
- rvfi_insn  out  32  encoded ADD instruction.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd  out  5 each  register addresses.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_post_rd  out  XLEN each  register data.
- rvfi_pre_pc, rvfi_post_pc  out  XLEN each  program counters.
- rvfi_trap  out  1  tied 0.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; all rvfi_* outputs 0; busy=0, done=0.
  - lfsr=SEED (1 if SEED==0); order counter=0; pc=RESET_PC; fault_pending=0.
  - Shadow register x[i]=i for i=0..31.
- FSM transitions:
  - IDLE -start-> RUN.
  - RUN -> DONE on the edge that emits record NUM_RECORDS-1.
  - DONE -start-> RUN; order and pc reset, shadow registers and LFSR keep their values.
  - start in RUN is ignored.
- Emission:
  - Condition: state==RUN && !stall, sampled at a clock edge.
  - All rvfi_* outputs are registered; the record appears with rvfi_valid=1 in the cycle after that edge.
  - rvfi_valid=0 in every cycle without an emission; data outputs hold their last values.
- Record fields, from the current lfsr value L (pre-advance):
  - rs1=L[4:0], rs2=L[9:5], rd=L[14:10].
  - insn={7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}.
- Record data:
  - rs1_rdata=x[rs1], rs2_rdata=x[rs2] (pre-write values).
  - post_rd=(rd==0) ? 0 : (x[rs1]+x[rs2]) mod 2^XLEN.
  - x[rd] is updated at the emitting edge when rd!=0; x0 is never written.
  - rs1 or rs2 equal to rd: reads return the old value.
- PC and order per emission:
  - pre_pc=pc, post_pc=pc+4 (mod 2^XLEN); pc<=pc+4.
  - order is 0-based and wraps mod 256.
- LFSR:
  - Advances once per emission: L<=(L>>1)^(L[0]?TAPS:0).
  - seed_load takes priority over the advance in the same cycle.
  - seed_load is allowed in any state.
- Fault injection:
  - fault_req sets fault_pending.
  - The next emission, including one at the same edge as fault_req, inverts bit 0 of the emitted rs1_rdata only, then clears fault_pending.
  - Shadow-register contents and post_rd are computed from the uncorrupted values.
  - Multiple fault_req pulses before an emission collapse into one fault.
- busy=(state==RUN), done=(state==DONE); both are registered alongside the state.
- Reset mid-run: all state returns to reset values immediately; no partial record is emitted.

Test Plan:
1. Reset, seed_load with 0x00000C41, start, stall=0 → first record: valid=1, order=0, rs1=1, rs2=2, rd=3, insn=0x002081B3, rs1_rdata=1, rs2_rdata=2, post_rd=3, pre_pc=0, post_pc=4.
2. NUM_RECORDS=4, stall=0 → exactly 4 valid records, orders 0..3, pre_pc 0,4,8,12; done=1 and busy=0 afterwards; valid stays 0 after that.
3. stall held high for 5 cycles mid-run → valid=0 for those cycles, no order gap, LFSR not advanced; the next record continues order+1.
4. Force a record with rd=0 via a chosen seed → post_rd=0 and x0 stays 0; a later read of x0 returns 0.
5. fault_req pulse during a stall, then release the stall → only the next record has rs1_rdata bit 0 flipped versus the shadow value; subsequent records are clean; the rvfi_reg_check instance fails on that record when rs1 matches its index.
6. resetn low mid-run, then high → outputs 0 and state IDLE; start replays the stream from SEED with x[i]=i.

Source files
------------

// File: rtl/rvfi_reg_gen.sv
// Synthetic RVFI retirement-record source: a stream of ADD instructions whose
// register operands come from a Galois LFSR, backed by a shadow register file
// so every record is architecturally consistent. An optional one-shot fault
// flips bit 0 of the next emitted rs1_rdata so downstream checkers can fire.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  pulse; begins a run from IDLE or DONE
//   stall                  suppresses emission this cycle
//   seed_load, seed_value  reload the LFSR (0 is treated as 1)
//   fault_req              corrupt the next emitted record
//   busy, done             registered state flags (RUN / DONE)
//   rvfi_*                 registered single-channel RVFI record
module rvfi_reg_gen #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NUM_RECORDS = 64,
    parameter logic [31:0]     SEED        = 32'h0000_0001,
    parameter logic [31:0]     TAPS        = 32'h8020_0003,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            stall,
    input  logic            seed_load,
    input  logic [31:0]     seed_value,
    input  logic            fault_req,
    output logic            busy,
    output logic            done,
    output logic            rvfi_valid,
    output logic [7:0]      rvfi_order,
    output logic [31:0]     rvfi_insn,
    output logic [4:0]      rvfi_rs1_addr,
    output logic [4:0]      rvfi_rs2_addr,
    output logic [4:0]      rvfi_rd,
    output logic [XLEN-1:0] rvfi_rs1_rdata,
    output logic [XLEN-1:0] rvfi_rs2_rdata,
    output logic [XLEN-1:0] rvfi_post_rd,
    output logic [XLEN-1:0] rvfi_pre_pc,
    output logic [XLEN-1:0] rvfi_post_pc,
    output logic            rvfi_trap
);

    localparam int unsigned CNT_W    = (NUM_RECORDS > 1) ? $clog2(NUM_RECORDS) : 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [6:0]  OP_ADD   = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   busy_d, done_d;

    logic [31:0]      lfsr;
    logic [XLEN-1:0]  pc;
    logic [7:0]       order_q;
    logic [CNT_W-1:0] rec_cnt;
    logic             fault_pending;
    logic [XLEN-1:0]  xreg [32];

    logic             emit_c;
    logic             last_c;
    logic             restart_c;
    logic             corrupt_c;
    logic [4:0]       rs1_c, rs2_c, rd_c;
    logic [XLEN-1:0]  rs1_val_c, rs2_val_c, sum_c;
    logic [31:0]      lfsr_adv_c;
    logic [31:0]      seed_eff_c;

    assign rvfi_trap = 1'b0;

    // Emission and run-boundary qualifiers
    assign emit_c    = (state == ST_RUN) && !stall;
    assign last_c    = emit_c && (rec_cnt == CNT_W'(NUM_RECORDS - 1));
    assign restart_c = start && (state != ST_RUN);

    // State register; busy/done are registered alongside it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)  state_next = ST_RUN;
            ST_RUN:  if (last_c) state_next = ST_DONE;
            ST_DONE: if (start)  state_next = ST_RUN;
            default:             state_next = ST_IDLE;
        endcase
    end

    // Flag values that accompany the next state
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_next == ST_RUN)  busy_d = 1'b1;
        if (state_next == ST_DONE) done_d = 1'b1;
    end

    // Record fields from the current (pre-advance) LFSR value
    always_comb begin
        rs1_c      = lfsr[4:0];
        rs2_c      = lfsr[9:5];
        rd_c       = lfsr[14:10];
        rs1_val_c  = xreg[rs1_c];
        rs2_val_c  = xreg[rs2_c];
        sum_c      = rs1_val_c + rs2_val_c;
        // A fault requested on the emitting edge itself is consumed immediately
        corrupt_c  = fault_pending || fault_req;
        lfsr_adv_c = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
        seed_eff_c = (seed_value == 32'h0) ? 32'h1 : seed_value;
    end

    // Generator state and shadow register file
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr          <= SEED_EFF;
            pc            <= RESET_PC;
            order_q       <= 8'd0;
            rec_cnt       <= '0;
            fault_pending <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                xreg[i] <= XLEN'(i);
            end
        end else begin
            if (seed_load) begin
                lfsr <= seed_eff_c;
            end else if (emit_c) begin
                lfsr <= lfsr_adv_c;
            end

            if (restart_c) begin
                pc      <= RESET_PC;
                order_q <= 8'd0;
                rec_cnt <= '0;
            end else if (emit_c) begin
                pc      <= pc + XLEN'(4);
                order_q <= order_q + 8'd1;
                rec_cnt <= rec_cnt + CNT_W'(1);
            end

            if (emit_c) begin
                fault_pending <= 1'b0;
            end else if (fault_req) begin
                fault_pending <= 1'b1;
            end

            // x0 is hardwired; post-write visibility starts next record
            if (emit_c && (rd_c != 5'd0)) begin
                xreg[rd_c] <= sum_c;
            end
        end
    end

    // Registered RVFI record; data holds between emissions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= 8'd0;
            rvfi_insn      <= 32'd0;
            rvfi_rs1_addr  <= 5'd0;
            rvfi_rs2_addr  <= 5'd0;
            rvfi_rd        <= 5'd0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_post_rd   <= '0;
            rvfi_pre_pc    <= '0;
            rvfi_post_pc   <= '0;
        end else begin
            rvfi_valid <= emit_c;
            if (emit_c) begin
                rvfi_order     <= order_q;
                rvfi_insn      <= {7'b0, rs2_c, rs1_c, 3'b000, rd_c, OP_ADD};
                rvfi_rs1_addr  <= rs1_c;
                rvfi_rs2_addr  <= rs2_c;
                rvfi_rd        <= rd_c;
                rvfi_rs1_rdata <= rs1_val_c ^ XLEN'(corrupt_c);
                rvfi_rs2_rdata <= rs2_val_c;
                rvfi_post_rd   <= (rd_c == 5'd0) ? '0 : sum_c;
                rvfi_pre_pc    <= pc;
                rvfi_post_pc   <= pc + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_rvfi_reg_gen.sv
// Directed bench for rvfi_reg_gen with NUM_RECORDS=4: seeded stream, stall,
// rd=0 / x0 reads, fault injection, run restart and reset mid-run.
module tb_rvfi_reg_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed_value = 32'h0;
    logic        fault_req = 1'b0;
    logic        busy, done, rvfi_valid, rvfi_trap;
    logic [7:0]  rvfi_order;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_post_rd;
    logic [31:0] rvfi_pre_pc, rvfi_post_pc;

    int checks = 0;
    int errors = 0;

    rvfi_reg_gen #(.NUM_RECORDS(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stall(stall),
        .seed_load(seed_load), .seed_value(seed_value), .fault_req(fault_req),
        .busy(busy), .done(done), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd(rvfi_rd),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_post_rd(rvfi_post_rd), .rvfi_pre_pc(rvfi_pre_pc),
        .rvfi_post_pc(rvfi_post_pc), .rvfi_trap(rvfi_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full record check: valid, order, addresses, insn, data, PCs
    task automatic chk_rec(input string tag, input int ord, input int r1, input int r2,
                           input int rd, input logic [31:0] insn, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] post,
                           input logic [31:0] ppc);
        chk({tag, ".valid"}, 32'(rvfi_valid), 32'd1);
        chk({tag, ".order"}, 32'(rvfi_order), 32'(ord));
        chk({tag, ".rs1"}, 32'(rvfi_rs1_addr), 32'(r1));
        chk({tag, ".rs2"}, 32'(rvfi_rs2_addr), 32'(r2));
        chk({tag, ".rd"}, 32'(rvfi_rd), 32'(rd));
        chk({tag, ".insn"}, rvfi_insn, insn);
        chk({tag, ".rs1_rdata"}, rvfi_rs1_rdata, d1);
        chk({tag, ".rs2_rdata"}, rvfi_rs2_rdata, d2);
        chk({tag, ".post_rd"}, rvfi_post_rd, post);
        chk({tag, ".pre_pc"}, rvfi_pre_pc, ppc);
        chk({tag, ".post_pc"}, rvfi_post_pc, ppc + 32'd4);
        chk({tag, ".trap"}, 32'(rvfi_trap), 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst.valid", 32'(rvfi_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.insn", rvfi_insn, 32'd0);
        chk("rst.pre_pc", rvfi_pre_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Run 1: seed 0xC41, start
        seed_load = 1'b1; seed_value = 32'h0000_0C41; start = 1'b1;
        step();
        seed_load = 1'b0; start = 1'b0;
        chk("r1.start.busy", 32'(busy), 32'd1);
        chk("r1.start.valid", 32'(rvfi_valid), 32'd0);
        step();
        chk_rec("r1.rec0", 0, 1, 2, 3, 32'h0020_81B3, 32'd1, 32'd2, 32'd3, 32'd0);
        step();
        // L=0x80200623: rs1=3 rs2=17 rd=1, x1 <= 20
        chk_rec("r1.rec1", 1, 3, 17, 1, 32'h0111_80B3, 32'd3, 32'd17, 32'd20, 32'd4);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r1.stall.valid", 32'(rvfi_valid), 32'd0);
            chk("r1.stall.hold_order", 32'(rvfi_order), 32'd1);
            chk("r1.stall.busy", 32'(busy), 32'd1);
        end
        stall = 1'b0;
        step();
        // L=0xC0300312: rs1=18 rs2=24 rd=0
        chk_rec("r1.rec2", 2, 18, 24, 0, 32'h0189_0033, 32'd18, 32'd24, 32'd0, 32'd8);
        chk("r1.rec2.busy", 32'(busy), 32'd1);
        step();
        // L=0x60180189: rs1=9 rs2=12 rd=0
        chk_rec("r1.rec3", 3, 9, 12, 0, 32'h00C4_8033, 32'd9, 32'd12, 32'd0, 32'd12);
        chk("r1.end.done", 32'(done), 32'd1);
        chk("r1.end.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r1.after.valid", 32'(rvfi_valid), 32'd0);
            chk("r1.after.done", 32'(done), 32'd1);
        end

        // Run 2: seed 0 -> 1, shadow regs persist from run 1
        seed_load = 1'b1; seed_value = 32'h0; start = 1'b1;
        step();
        seed_load = 1'b0; start = 1'b0;
        chk("r2.start.busy", 32'(busy), 32'd1);
        chk("r2.start.done", 32'(done), 32'd0);
        step();
        // L=1: rs1=1 (x1=20) rs2=0 rd=0
        chk_rec("r2.rec0", 0, 1, 0, 0, 32'h0000_8033, 32'd20, 32'd0, 32'd0, 32'd0);
        stall = 1'b1;
        step();
        fault_req = 1'b1;
        step();
        fault_req = 1'b0;
        step();
        fault_req = 1'b1;
        step();
        fault_req = 1'b0;
        chk("r2.stall.valid", 32'(rvfi_valid), 32'd0);
        stall = 1'b0;
        step();
        // L=0x80200003: rs1=3 (x3=3, corrupted to 2) rs2=0 rd=0
        chk_rec("r2.rec1.fault", 1, 3, 0, 0, 32'h0001_8033, 32'd2, 32'd0, 32'd0, 32'd4);
        step();
        // L=0xC0300002: rs1=2 clean
        chk_rec("r2.rec2", 2, 2, 0, 0, 32'h0001_0033, 32'd2, 32'd0, 32'd0, 32'd8);
        step();
        // L=0x60180001: rs1=1 clean, x1 still 20
        chk_rec("r2.rec3", 3, 1, 0, 0, 32'h0000_8033, 32'd20, 32'd0, 32'd0, 32'd12);
        chk("r2.end.done", 32'(done), 32'd1);

        // Run 3, interrupted by reset
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("r3.rec0.valid", 32'(rvfi_valid), 32'd1);
        chk("r3.rec0.order", 32'(rvfi_order), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst.valid", 32'(rvfi_valid), 32'd0);
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.rs1_rdata", rvfi_rs1_rdata, 32'd0);
        chk("mrst.post_pc", rvfi_post_pc, 32'd0);
        step();
        chk("mrst.hold.valid", 32'(rvfi_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("idle.busy", 32'(busy), 32'd0);
        chk("idle.valid", 32'(rvfi_valid), 32'd0);

        // Replay from SEED=1 with x[i]=i
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_rec("r4.rec0", 0, 1, 0, 0, 32'h0000_8033, 32'd1, 32'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
